// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: field positions of the
// instruction word, fetch defaults and the fetch-state encoding.
package cpu_pkg;

    // Default RAM word-address width and the word that stops fetch.
    localparam int          ADDR_W_DEF    = 16;
    localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

    // Field bit positions inside a 32-bit instruction word.
    localparam int COND_MSB      = 31;
    localparam int COND_LSB      = 28;
    localparam int OPCODE_MSB    = 27;
    localparam int OPCODE_LSB    = 24;
    localparam int S_BIT         = 23;
    localparam int DEST_MSB      = 22;
    localparam int DEST_LSB      = 19;
    localparam int SRC2_MSB      = 18;
    localparam int SRC2_LSB      = 15;
    localparam int SRC1_MSB      = 14;
    localparam int SRC1_LSB      = 11;
    localparam int SHIFT_MSB     = 10;
    localparam int SHIFT_LSB     = 6;
    localparam int MOV_MSB       = 18;
    localparam int MOV_LSB       = 3;

    // Lowest bit any field looks at; bits below it carry no decoded meaning.
    localparam int FIELD_LOW_BIT = 3;

    // Fetch sequencer states (legacy-compatible constant encoding).
    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t ST_FETCH = 2'd0;
    localparam fetch_state_t ST_LATCH = 2'd1;
    localparam fetch_state_t ST_HOLD  = 2'd2;
    localparam fetch_state_t ST_HALT  = 2'd3;

endpackage

// File: rtl/instr_field_split.sv
// Combinational splitter: slices an instruction word into its fields.
// Only bits FIELD_LOW_BIT and above are decoded, so only those are taken in.
module instr_field_split
    import cpu_pkg::*;
(
    input  logic [31:FIELD_LOW_BIT] word_bits,
    output logic [3:0]              Cond,
    output logic [3:0]              OpCode,
    output logic                    S,
    output logic [3:0]              destination,
    output logic [3:0]              source_2,
    output logic [3:0]              source_1,
    output logic [4:0]              IV_ShiftRor,
    output logic [15:0]             IV_Mov
);

    // Pure bit slicing; fields overlap by design (IV_Mov spans source fields).
    always_comb begin
        Cond        = word_bits[COND_MSB:COND_LSB];
        OpCode      = word_bits[OPCODE_MSB:OPCODE_LSB];
        S           = word_bits[S_BIT];
        destination = word_bits[DEST_MSB:DEST_LSB];
        source_2    = word_bits[SRC2_MSB:SRC2_LSB];
        source_1    = word_bits[SRC1_MSB:SRC1_LSB];
        IV_ShiftRor = word_bits[SHIFT_MSB:SHIFT_LSB];
        IV_Mov      = word_bits[MOV_MSB:MOV_LSB];
    end

endmodule

// File: rtl/instruction_fetch.sv
// Front-end fetch stage: owns the program counter, reads the instruction
// RAM once per word, holds the word under a valid/stall handshake, and
// handles branch redirect and halt detection.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] PC_RESET  = 16'h0000,
    parameter logic [31:0]       HALT_WORD = HALT_WORD_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Stall,
    input  logic              Branch_en,
    input  logic [ADDR_W-1:0] Branch_addr,
    output logic              Enable,
    output logic              RW_ram,
    output logic [ADDR_W-1:0] Address_in,
    input  logic [31:0]       Out,
    output logic [31:0]       instruction,
    output logic              Instr_valid,
    output logic [ADDR_W-1:0] PC,
    output logic              Halted,
    output logic [3:0]        Cond,
    output logic [3:0]        OpCode,
    output logic              S,
    output logic [3:0]        destination,
    output logic [3:0]        source_2,
    output logic [3:0]        source_1,
    output logic [4:0]        IV_ShiftRor,
    output logic [15:0]       IV_Mov
);

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    fetch_state_t      state_r;
    logic [ADDR_W-1:0] fetch_pc_r;
    logic [ADDR_W-1:0] pc_r;
    logic [31:0]       instruction_r;
    logic              instr_valid_r;
    logic              halted_r;

    // Sequencer: Reset first, then branch redirect, then normal state flow.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r       <= ST_FETCH;
            fetch_pc_r    <= PC_RESET;
            pc_r          <= PC_RESET;
            instruction_r <= 32'h0000_0000;
            instr_valid_r <= 1'b0;
            halted_r      <= 1'b0;
        end else if (Branch_en) begin
            // Any read in flight and any held word are dropped.
            fetch_pc_r    <= Branch_addr;
            instr_valid_r <= 1'b0;
            halted_r      <= 1'b0;
            state_r       <= ST_FETCH;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    state_r <= ST_LATCH;
                end
                ST_LATCH: begin
                    instruction_r <= Out;
                    pc_r          <= fetch_pc_r;
                    fetch_pc_r    <= fetch_pc_r + PC_ONE;
                    if (Out == HALT_WORD) begin
                        instr_valid_r <= 1'b0;
                        halted_r      <= 1'b1;
                        state_r       <= ST_HALT;
                    end else begin
                        instr_valid_r <= 1'b1;
                        state_r       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (Stall) begin
                        state_r <= ST_HOLD;
                    end else begin
                        instr_valid_r <= 1'b0;
                        state_r       <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                end
                default: begin
                    instr_valid_r <= 1'b0;
                    state_r       <= ST_FETCH;
                end
            endcase
        end
    end

    // RAM request: one read per word, issued only in FETCH and never while
    // Reset is asserted, so the first read lands the cycle after Reset drops.
    always_comb begin
        Enable     = (state_r == ST_FETCH) && !Reset;
        RW_ram     = 1'b1;
        Address_in = fetch_pc_r;
    end

    // Registered state presented to downstream stages.
    always_comb begin
        instruction = instruction_r;
        Instr_valid = instr_valid_r;
        PC          = pc_r;
        Halted      = halted_r;
    end

    instr_field_split u_split (
        .word_bits   (instruction_r[31:FIELD_LOW_BIT]),
        .Cond        (Cond),
        .OpCode      (OpCode),
        .S           (S),
        .destination (destination),
        .source_2    (source_2),
        .source_1    (source_1),
        .IV_ShiftRor (IV_ShiftRor),
        .IV_Mov      (IV_Mov)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural one-cycle RAM.
module tb_instruction_fetch;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Stall;
    logic        Branch_en;
    logic [15:0] Branch_addr;
    logic        Enable;
    logic        RW_ram;
    logic [15:0] Address_in;
    logic [31:0] Out = 32'h0000_0000;
    logic [31:0] instruction;
    logic        Instr_valid;
    logic [15:0] PC;
    logic        Halted;
    logic [3:0]  Cond, OpCode, destination, source_2, source_1;
    logic        S;
    logic [4:0]  IV_ShiftRor;
    logic [15:0] IV_Mov;

    int checks = 0;
    int errors = 0;

    logic [31:0] ram [logic [15:0]];
    logic [31:0] seq_words [0:3];

    instruction_fetch dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Branch_en(Branch_en),
        .Branch_addr(Branch_addr), .Enable(Enable), .RW_ram(RW_ram),
        .Address_in(Address_in), .Out(Out), .instruction(instruction),
        .Instr_valid(Instr_valid), .PC(PC), .Halted(Halted), .Cond(Cond),
        .OpCode(OpCode), .S(S), .destination(destination),
        .source_2(source_2), .source_1(source_1),
        .IV_ShiftRor(IV_ShiftRor), .IV_Mov(IV_Mov)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] ram_rd(input logic [15:0] a);
        return ram.exists(a) ? ram[a] : 32'h0000_0000;
    endfunction

    // RAM returns data the cycle after a sampled read request.
    always @(posedge Clk) begin
        if (Enable) Out <= ram_rd(Address_in);
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        seq_words[0] = 32'h0A00_0000;
        seq_words[1] = 32'h0A80_0001;
        seq_words[2] = 32'h0A00_0002;
        seq_words[3] = 32'h0A00_0003;
        for (int i = 0; i < 4; i++) ram[16'(i)] = seq_words[i];
        ram[16'h0040] = 32'h1234_5678;
        ram[16'h0005] = 32'hFFFF_FFFF;
        ram[16'hFFFF] = 32'h0BAD_F00D;

        // Reset for two cycles.
        Reset = 1'b1; Stall = 1'b0; Branch_en = 1'b0; Branch_addr = 16'h0000;
        step(); step();
        chk("rst_enable", {31'd0, Enable}, 32'd0);
        chk("rst_rw", {31'd0, RW_ram}, 32'd1);
        chk("rst_valid", {31'd0, Instr_valid}, 32'd0);
        chk("rst_pc", {16'd0, PC}, 32'd0);
        chk("rst_instr", instruction, 32'd0);
        chk("rst_halted", {31'd0, Halted}, 32'd0);
        Reset = 1'b0;
        #1;

        // Sequential fetch with a 5-cycle stall on word 1.
        for (int i = 0; i < 4; i++) begin
            chk("seq_en", {31'd0, Enable}, 32'd1);
            chk("seq_addr", {16'd0, Address_in}, 32'(i));
            step();
            chk("latch_en", {31'd0, Enable}, 32'd0);
            chk("latch_valid", {31'd0, Instr_valid}, 32'd0);
            step();
            chk("seq_valid", {31'd0, Instr_valid}, 32'd1);
            chk("seq_pc", {16'd0, PC}, 32'(i));
            chk("seq_instr", instruction, seq_words[i]);
            chk("hold_en", {31'd0, Enable}, 32'd0);
            if (i == 1) begin
                Stall = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    step();
                    chk("stall_valid", {31'd0, Instr_valid}, 32'd1);
                    chk("stall_pc", {16'd0, PC}, 32'd1);
                    chk("stall_instr", instruction, seq_words[1]);
                    chk("stall_en", {31'd0, Enable}, 32'd0);
                end
                Stall = 1'b0;
            end
            if (i < 3) step();
        end

        // Branch while held under stall.
        Stall = 1'b1; Branch_en = 1'b1; Branch_addr = 16'h0040;
        step();
        Branch_en = 1'b0; Stall = 1'b0;
        chk("br_valid", {31'd0, Instr_valid}, 32'd0);
        chk("br_en", {31'd0, Enable}, 32'd1);
        chk("br_addr", {16'd0, Address_in}, 32'h0040);
        step(); step();
        chk("br_tgt_valid", {31'd0, Instr_valid}, 32'd1);
        chk("br_tgt_pc", {16'd0, PC}, 32'h0040);
        chk("br_tgt_instr", instruction, 32'h1234_5678);

        // Halt on fetching the halt word at address 5.
        Branch_en = 1'b1; Branch_addr = 16'h0005;
        step();
        Branch_en = 1'b0;
        chk("h_addr", {16'd0, Address_in}, 32'h0005);
        step(); step();
        chk("h_halted", {31'd0, Halted}, 32'd1);
        chk("h_valid", {31'd0, Instr_valid}, 32'd0);
        for (int k = 0; k < 20; k++) begin
            step();
            chk("h_en_idle", {31'd0, Enable}, 32'd0);
            chk("h_stays", {31'd0, Halted}, 32'd1);
        end
        Branch_en = 1'b1; Branch_addr = 16'h0000;
        step();
        Branch_en = 1'b0;
        chk("h_clear", {31'd0, Halted}, 32'd0);
        chk("h_resume_en", {31'd0, Enable}, 32'd1);
        chk("h_resume_addr", {16'd0, Address_in}, 32'h0000);

        // Wrap from 16'hFFFF to 16'h0000.
        Branch_en = 1'b1; Branch_addr = 16'hFFFF;
        step();
        Branch_en = 1'b0;
        chk("w_addr", {16'd0, Address_in}, 32'h0000_FFFF);
        step(); step();
        chk("w_valid", {31'd0, Instr_valid}, 32'd1);
        chk("w_pc", {16'd0, PC}, 32'h0000_FFFF);
        chk("w_instr", instruction, 32'h0BAD_F00D);
        step();
        chk("w_next_en", {31'd0, Enable}, 32'd1);
        chk("w_next_addr", {16'd0, Address_in}, 32'h0000);

        // Reset while a word is held under stall.
        step(); step();
        chk("rs_pre_instr", instruction, seq_words[0]);
        Stall = 1'b1;
        step();
        Reset = 1'b1;
        step();
        chk("rs_valid", {31'd0, Instr_valid}, 32'd0);
        chk("rs_instr", instruction, 32'd0);
        chk("rs_en", {31'd0, Enable}, 32'd0);
        chk("rs_addr", {16'd0, Address_in}, 32'h0000);

        // Field decode of a fresh word at address 0.
        ram[16'h0000] = 32'hE1C4_B2C8;
        Reset = 1'b0; Stall = 1'b0;
        #1;
        step(); step();
        chk("f_valid", {31'd0, Instr_valid}, 32'd1);
        chk("f_cond", {28'd0, Cond}, 32'hE);
        chk("f_opcode", {28'd0, OpCode}, 32'h1);
        chk("f_s", {31'd0, S}, 32'd1);
        chk("f_dest", {28'd0, destination}, 32'h8);
        chk("f_src2", {28'd0, source_2}, 32'h9);
        chk("f_src1", {28'd0, source_1}, 32'h6);
        chk("f_shift", {27'd0, IV_ShiftRor}, 32'd11);
        chk("f_mov", {16'd0, IV_Mov}, 32'h9659);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
